// File: rtl/key_lock_pkg.sv
// Shared types and width helpers for the multi-word key lock.
package key_lock_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        GRANT   = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    function automatic int fail_count_width(input int max_fail);
        return $clog2(max_fail + 1);
    endfunction

    // A single-word key still needs a one-bit index register.
    function automatic int index_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/key_lock_timer.sv
// Loadable down-counter that times the lockout.
// done is high in the last counted cycle, while the count is 1.
module key_lock_timer #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(LOCK_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(LOCK_CYCLES);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == CW'(1));

endmodule

// File: rtl/key_lock_fsm.sv
// Serial multi-word key gate: grants SECRET on a full key match.
// Consecutive failed attempts lead to a timed lockout.
module key_lock_fsm
    import key_lock_pkg::*;
#(
    parameter int                          WIDTH       = 32,
    parameter int                          KEY_WORDS   = 2,
    parameter logic [WIDTH*KEY_WORDS-1:0]  KEY_VALUE   = 64'h4C6F7452_21434146,
    parameter logic [WIDTH-1:0]            SECRET      = 32'h00464C45,
    parameter int                          MAX_FAIL    = 3,
    parameter int                          LOCK_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 key_valid,
    output logic                                 key_ready,
    input  logic [WIDTH-1:0]                     key,
    input  logic                                 clear,
    output logic [WIDTH-1:0]                     data,
    output logic                                 data_valid,
    output logic                                 locked,
    output logic [fail_count_width(MAX_FAIL)-1:0] fail_count
);

    localparam int FW = fail_count_width(MAX_FAIL);
    localparam int IW = index_width(KEY_WORDS);

    state_t          state;
    logic [IW-1:0]   idx;
    logic            mismatch;

    logic [WIDTH-1:0] expected_word;
    logic             transfer;
    logic             last_word;
    logic             mismatch_next;
    logic [FW-1:0]    fail_inc;
    logic             trip;
    logic             timer_done;

    assign key_ready = (state == COLLECT);

    // Word 0 is the most significant slice of KEY_VALUE.
    always_comb begin
        expected_word = KEY_VALUE[WIDTH*(KEY_WORDS-1-int'(idx)) +: WIDTH];
        transfer      = key_valid && key_ready && !clear;
        last_word     = (idx == IW'(KEY_WORDS-1));
        mismatch_next = mismatch | (key != expected_word);
        fail_inc      = fail_count + FW'(1);
        trip          = transfer && last_word && mismatch_next && (fail_inc == FW'(MAX_FAIL));
    end

    key_lock_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (trip),
        .done (timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            idx        <= '0;
            mismatch   <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            fail_count <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (clear) begin
                        idx      <= '0;
                        mismatch <= 1'b0;
                    end else if (transfer) begin
                        if (last_word) begin
                            idx      <= '0;
                            mismatch <= 1'b0;
                            if (!mismatch_next) begin
                                state      <= GRANT;
                                data       <= SECRET;
                                data_valid <= 1'b1;
                                fail_count <= '0;
                            end else begin
                                fail_count <= fail_inc;
                                if (trip) begin
                                    state  <= LOCKOUT;
                                    locked <= 1'b1;
                                end
                            end
                        end else begin
                            idx      <= idx + IW'(1);
                            mismatch <= mismatch_next;
                        end
                    end
                end
                GRANT: begin
                    if (clear) begin
                        state      <= COLLECT;
                        data       <= '0;
                        data_valid <= 1'b0;
                        idx        <= '0;
                    end
                end
                LOCKOUT: begin
                    // clear has no effect here; only the timer ends lockout.
                    if (timer_done) begin
                        state      <= COLLECT;
                        locked     <= 1'b0;
                        fail_count <= '0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_lock_fsm.sv
// Bench for key_lock_fsm: default instance (index 0) and a one-word,
// single-failure, short-lockout instance (index 1), checked against a model.
module tb_key_lock_fsm;

    localparam logic [31:0] W0     = 32'h4C6F7452;
    localparam logic [31:0] W1     = 32'h21434146;
    localparam logic [31:0] SECRET = 32'h00464C45;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        kv  [2];
    logic        clr [2];
    logic [31:0] k   [2];

    logic        key_ready_a, data_valid_a, locked_a;
    logic [31:0] data_a;
    logic [1:0]  fail_a;
    logic        key_ready_b, data_valid_b, locked_b;
    logic [31:0] data_b;
    logic [0:0]  fail_b;

    key_lock_fsm dut_a (
        .clk        (clk),
        .rst        (rst[0]),
        .key_valid  (kv[0]),
        .key_ready  (key_ready_a),
        .key        (k[0]),
        .clear      (clr[0]),
        .data       (data_a),
        .data_valid (data_valid_a),
        .locked     (locked_a),
        .fail_count (fail_a)
    );

    key_lock_fsm #(
        .WIDTH       (32),
        .KEY_WORDS   (1),
        .KEY_VALUE   (32'h4C6F7452),
        .SECRET      (32'h00464C45),
        .MAX_FAIL    (1),
        .LOCK_CYCLES (2)
    ) dut_b (
        .clk        (clk),
        .rst        (rst[1]),
        .key_valid  (kv[1]),
        .key_ready  (key_ready_b),
        .key        (k[1]),
        .clear      (clr[1]),
        .data       (data_b),
        .data_valid (data_valid_b),
        .locked     (locked_b),
        .fail_count (fail_b)
    );

    // Reference model: an attempt is the concatenation of its words,
    // compared whole against the key once enough words have arrived.
    int          m_kw   [2] = '{2, 1};
    int          m_mf   [2] = '{3, 1};
    int          m_lc   [2] = '{16, 2};
    logic [63:0] m_key  [2] = '{64'h4C6F7452_21434146, 64'h0000_0000_4C6F7452};
    logic [63:0] m_acc  [2];
    int          m_cnt  [2];
    int          m_fails[2];
    int          m_lock [2];
    bit          m_grant[2];

    int checks = 0;
    int errors = 0;

    task automatic model_step(input int d);
        if (rst[d]) begin
            m_acc[d] = '0; m_cnt[d] = 0; m_fails[d] = 0; m_lock[d] = 0; m_grant[d] = 0;
        end else if (m_lock[d] > 0) begin
            m_lock[d]--;
            if (m_lock[d] == 0) m_fails[d] = 0;
        end else if (m_grant[d]) begin
            if (clr[d]) m_grant[d] = 0;
        end else if (clr[d]) begin
            m_acc[d] = '0; m_cnt[d] = 0;
        end else if (kv[d]) begin
            m_acc[d] = {m_acc[d][31:0], k[d]};
            m_cnt[d]++;
            if (m_cnt[d] == m_kw[d]) begin
                if (m_acc[d] == m_key[d]) begin
                    m_grant[d] = 1; m_fails[d] = 0;
                end else begin
                    m_fails[d]++;
                    if (m_fails[d] == m_mf[d]) m_lock[d] = m_lc[d];
                end
                m_acc[d] = '0; m_cnt[d] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] o_ready, o_data, o_valid, o_locked, o_fail;
            if (d == 0) begin
                o_ready = {31'b0, key_ready_a}; o_data = data_a; o_valid = {31'b0, data_valid_a};
                o_locked = {31'b0, locked_a}; o_fail = {30'b0, fail_a};
            end else begin
                o_ready = {31'b0, key_ready_b}; o_data = data_b; o_valid = {31'b0, data_valid_b};
                o_locked = {31'b0, locked_b}; o_fail = {31'b0, fail_b};
            end
            check("key_ready",  d, o_ready,  32'(!m_grant[d] && m_lock[d] == 0));
            check("data",       d, o_data,   m_grant[d] ? SECRET : 32'h0);
            check("data_valid", d, o_valid,  32'(m_grant[d]));
            check("locked",     d, o_locked, 32'(m_lock[d] > 0));
            check("fail_count", d, o_fail,   32'(m_fails[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic send(input int d, input logic [31:0] w);
        kv[d] = 1'b1; k[d] = w;
        tick();
        kv[d] = 1'b0;
    endtask

    task automatic do_clear(input int d);
        clr[d] = 1'b1;
        tick();
        clr[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; kv[d] = 1'b0; clr[d] = 1'b0; k[d] = '0;
        end
        @(negedge clk);
        idle(2);
        rst[0] = 1'b0; rst[1] = 1'b0;
        idle(1);

        // Correct key, grant held, then release.
        send(0, W0); send(0, W1);
        idle(2);
        do_clear(0);

        // Single failure, then a correct key clears the count.
        send(0, W0); send(0, 32'h0);
        send(0, W0); send(0, W1);
        do_clear(0);

        // Three wrong attempts -> lockout; words offered during it are ignored.
        for (int i = 0; i < 3; i++) begin
            send(0, 32'hDEAD_0000 + 32'(i)); send(0, W1 ^ 32'h1);
        end
        kv[0] = 1'b1; k[0] = W0; clr[0] = 1'b1;
        idle(16);
        kv[0] = 1'b0; clr[0] = 1'b0;
        send(0, W0); send(0, W1);
        do_clear(0);

        // Abort: clear with a valid word drops it.
        send(0, W0);
        kv[0] = 1'b1; k[0] = W1; clr[0] = 1'b1;
        tick();
        kv[0] = 1'b0; clr[0] = 1'b0;
        send(0, W1);
        send(0, W0); send(0, W1);
        do_clear(0);

        // Early mismatch is sticky; reset during lockout.
        send(0, 32'h0000_BEEF); send(0, W1);
        send(0, 32'h1); send(0, 32'h2);
        send(0, 32'h3); send(0, 32'h4);
        idle(3);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        idle(1);

        // One-word instance: lock on one miss for two cycles, then grant.
        send(1, 32'h1234_5678);
        idle(3);
        send(1, W0);
        idle(1);
        do_clear(1);

        // Randomised traffic on both instances.
        repeat (500) begin
            for (int d = 0; d < 2; d++) begin
                logic [63:0] sh;
                sh = m_key[d] >> (32 * (m_kw[d] - 1 - m_cnt[d]));
                rst[d] = ($urandom_range(0, 63) == 0);
                clr[d] = ($urandom_range(0, 9) == 0);
                kv[d]  = ($urandom_range(0, 2) != 0);
                k[d]   = ($urandom_range(0, 9) < 7) ? sh[31:0] : $urandom;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
